// File: rtl/trig_encoder_q.sv
// trig_encoder_q
//   Registered, queued 3-bit trigger encoder for NCH CFEB channels.
//   Each cycle every channel's {RESYNC_RST, L1A_MATCH[i], L1ACFEB, PRE_LCT_OUT[i]}
//   is mapped to a 3-bit code. Non-zero codes are queued per channel and
//   replayed onto ENC_BIT2..0 with a HOLD-cycle minimum pulse followed by a
//   GAP-cycle idle gap, so back-to-back events are neither lost nor merged.
//   When ENCODE is low or DCFEB_IN_USE is high the block is a registered
//   pass-through of the legacy signals.
//
// Ports
//   CLK, RST_N       clock, asynchronous active-low reset
//   ENCODE           1 = encoded mode
//   DCFEB_IN_USE     1 = DCFEB legacy mode (overrides ENCODE)
//   RESYNC_RST       resync, common to all channels
//   L1ACFEB          L1A to CFEBs, common to all channels
//   PRE_LCT_OUT[NCH] per-channel pre-LCT
//   L1A_MATCH[NCH]   per-channel L1A match
//   CLR_OVF          synchronous clear of OVERFLOW
//   ENC_BIT0..2[NCH] registered code bits
//   BUSY[NCH]        code/gap in progress or codes queued
//   OVERFLOW[NCH]    sticky: a code was dropped on a full queue
module trig_encoder_q #(
    parameter int NCH   = 5,
    parameter int DEPTH = 4,
    parameter int HOLD  = 2,
    parameter int GAP   = 1
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           ENCODE,
    input  logic           DCFEB_IN_USE,
    input  logic           RESYNC_RST,
    input  logic           L1ACFEB,
    input  logic [NCH-1:0] PRE_LCT_OUT,
    input  logic [NCH-1:0] L1A_MATCH,
    input  logic           CLR_OVF,
    output logic [NCH-1:0] ENC_BIT0,
    output logic [NCH-1:0] ENC_BIT1,
    output logic [NCH-1:0] ENC_BIT2,
    output logic [NCH-1:0] BUSY,
    output logic [NCH-1:0] OVERFLOW
);

    localparam int MAXC = (HOLD > GAP) ? HOLD : GAP;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int AW   = $clog2(DEPTH);
    localparam int FW   = AW + 1;

    localparam logic [CW-1:0] HOLD_C = CW'(HOLD);
    localparam logic [CW-1:0] GAP_C  = CW'(GAP);
    localparam logic [FW-1:0] FULL_C = FW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    logic enc_mode;
    assign enc_mode = ENCODE & ~DCFEB_IN_USE;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t        state, state_nx;
        logic [CW-1:0] cnt, cnt_nx;
        logic [2:0]    cur, cur_nx;
        logic [2:0]    code;
        logic [2:0]    fifo [DEPTH];
        logic [AW-1:0] rd_ptr, wr_ptr;
        logic [FW-1:0] fcnt, fcnt_nx;
        logic          push, pop, flush, ovf_set;
        logic          done, may_bypass, bypass;
        logic [2:0]    lines;
        logic          busy_q, ovf_q;

        always_comb begin
            code = 3'd0;
            casez ({RESYNC_RST, L1A_MATCH[i], L1ACFEB, PRE_LCT_OUT[i]})
                4'b1???: code = 3'd7;
                4'b0001: code = 3'd1;
                4'b0011: code = 3'd2;
                4'b0111: code = 3'd3;
                4'b0010: code = 3'd4;
                4'b0110: code = 3'd5;
                default: code = 3'd0;
            endcase
        end

        always_comb begin
            state_nx   = state;
            cnt_nx     = cnt;
            cur_nx     = cur;
            push       = 1'b0;
            pop        = 1'b0;
            flush      = 1'b0;
            ovf_set    = 1'b0;
            done       = 1'b0;
            may_bypass = 1'b0;
            bypass     = 1'b0;
            if (!enc_mode) begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
                cur_nx   = '0;
                flush    = 1'b1;
            end else if (RESYNC_RST) begin
                // Counter held at 0 while resync is high, so HOLD full
                // cycles of code 7 follow its falling edge.
                state_nx = S_SEND;
                cnt_nx   = '0;
                cur_nx   = 3'd7;
                flush    = 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        done       = 1'b1;
                        may_bypass = 1'b1;
                    end
                    S_SEND: begin
                        if (cnt >= HOLD_C) begin
                            if (GAP > 0) begin
                                state_nx = S_GAP;
                                cnt_nx   = CW'(1);
                            end else begin
                                done = 1'b1;
                            end
                        end else begin
                            cnt_nx = cnt + CW'(1);
                        end
                    end
                    S_GAP: begin
                        if (cnt >= GAP_C) done = 1'b1;
                        else              cnt_nx = cnt + CW'(1);
                    end
                    default: done = 1'b1;
                endcase

                // End of a hold/gap takes the idle decision in the same
                // cycle so a queued code follows the gap without a bubble.
                // Only a genuinely idle channel may bypass the queue.
                if (done) begin
                    if (fcnt != '0) begin
                        pop      = 1'b1;
                        state_nx = S_SEND;
                        cnt_nx   = CW'(1);
                        cur_nx   = fifo[rd_ptr];
                    end else if (may_bypass && code != 3'd0) begin
                        bypass   = 1'b1;
                        state_nx = S_SEND;
                        cnt_nx   = CW'(1);
                        cur_nx   = code;
                    end else begin
                        state_nx = S_IDLE;
                        cnt_nx   = '0;
                        cur_nx   = '0;
                    end
                end

                if (code != 3'd0 && !bypass) begin
                    if (fcnt == FULL_C && !pop) ovf_set = 1'b1;
                    else                        push    = 1'b1;
                end
            end
            fcnt_nx = flush ? '0 : fcnt + FW'(push) - FW'(pop);
        end

        always_ff @(posedge CLK) begin
            if (push) fifo[wr_ptr] <= code;
        end

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                state  <= S_IDLE;
                cnt    <= '0;
                cur    <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                fcnt   <= '0;
                lines  <= '0;
                busy_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
                cur   <= cur_nx;
                fcnt  <= fcnt_nx;
                if (flush) begin
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                end else begin
                    if (push) wr_ptr <= wr_ptr + AW'(1);
                    if (pop)  rd_ptr <= rd_ptr + AW'(1);
                end
                if (ovf_set)      ovf_q <= 1'b1;
                else if (CLR_OVF) ovf_q <= 1'b0;
                if (!enc_mode) begin
                    lines  <= {RESYNC_RST, L1ACFEB,
                               DCFEB_IN_USE ? L1A_MATCH[i] : PRE_LCT_OUT[i]};
                    busy_q <= 1'b0;
                end else begin
                    lines  <= (state_nx == S_SEND) ? cur_nx : 3'd0;
                    busy_q <= (state_nx != S_IDLE) || (fcnt_nx != '0);
                end
            end
        end

        assign ENC_BIT0[i] = lines[0];
        assign ENC_BIT1[i] = lines[1];
        assign ENC_BIT2[i] = lines[2];
        assign BUSY[i]     = busy_q;
        assign OVERFLOW[i] = ovf_q;
    end

endmodule

// File: tb/tb_trig_encoder_q.sv
// tb_trig_encoder_q
//   Directed and randomized bench for trig_encoder_q with default parameters.
//   A behavioural model (per-channel code queue plus remaining-send and
//   remaining-gap cycle counts) predicts every output after every clock.
module tb_trig_encoder_q;

    localparam int NCH   = 5;
    localparam int DEPTH = 4;
    localparam int HOLD  = 2;
    localparam int GAP   = 1;

    logic           CLK = 1'b0;
    logic           RST_N;
    logic           ENCODE;
    logic           DCFEB_IN_USE;
    logic           RESYNC_RST;
    logic           L1ACFEB;
    logic [NCH-1:0] PRE_LCT_OUT;
    logic [NCH-1:0] L1A_MATCH;
    logic           CLR_OVF;
    logic [NCH-1:0] ENC_BIT0;
    logic [NCH-1:0] ENC_BIT1;
    logic [NCH-1:0] ENC_BIT2;
    logic [NCH-1:0] BUSY;
    logic [NCH-1:0] OVERFLOW;

    int n_assert = 0;
    int n_fail   = 0;

    trig_encoder_q #(
        .NCH   (NCH),
        .DEPTH (DEPTH),
        .HOLD  (HOLD),
        .GAP   (GAP)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .ENCODE       (ENCODE),
        .DCFEB_IN_USE (DCFEB_IN_USE),
        .RESYNC_RST   (RESYNC_RST),
        .L1ACFEB      (L1ACFEB),
        .PRE_LCT_OUT  (PRE_LCT_OUT),
        .L1A_MATCH    (L1A_MATCH),
        .CLR_OVF      (CLR_OVF),
        .ENC_BIT0     (ENC_BIT0),
        .ENC_BIT1     (ENC_BIT1),
        .ENC_BIT2     (ENC_BIT2),
        .BUSY         (BUSY),
        .OVERFLOW     (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    int             mq    [NCH][DEPTH];
    int             mlen  [NCH];
    int             mcur  [NCH];
    int             msend [NCH];   // cycles of code still to show
    int             mgap  [NCH];   // cycles of gap still to show
    bit             movf  [NCH];
    logic [NCH-1:0] exp_b0, exp_b1, exp_b2, exp_busy, exp_ovf;

    function automatic int enc_code(input bit r, input bit m, input bit l, input bit p);
        if (r) return 7;
        case ({m, l, p})
            3'b000:  return 0;
            3'b001:  return 1;
            3'b011:  return 2;
            3'b111:  return 3;
            3'b010:  return 4;
            3'b110:  return 5;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            mlen[i]  = 0;
            mcur[i]  = 0;
            msend[i] = 0;
            mgap[i]  = 0;
            movf[i]  = 1'b0;
        end
        exp_b0 = '0; exp_b1 = '0; exp_b2 = '0; exp_busy = '0; exp_ovf = '0;
    endtask

    task automatic model_clock();
        bit enc;
        enc = ENCODE && !DCFEB_IN_USE;
        for (int i = 0; i < NCH; i++) begin
            int c, outc;
            bit decide, may_bypass, taken, drop;
            c = enc_code(RESYNC_RST, L1A_MATCH[i], L1ACFEB, PRE_LCT_OUT[i]);
            decide = 0; may_bypass = 0; taken = 0; drop = 0;
            if (!enc) begin
                mlen[i] = 0; msend[i] = 0; mgap[i] = 0;
                exp_b0[i]   = DCFEB_IN_USE ? L1A_MATCH[i] : PRE_LCT_OUT[i];
                exp_b1[i]   = L1ACFEB;
                exp_b2[i]   = RESYNC_RST;
                exp_busy[i] = 1'b0;
            end else begin
                if (RESYNC_RST) begin
                    mlen[i] = 0; mcur[i] = 7; msend[i] = HOLD + 1; mgap[i] = 0;
                end else begin
                    if (msend[i] > 1) msend[i]--;
                    else if (msend[i] == 1) begin
                        msend[i] = 0;
                        if (GAP > 0) mgap[i] = GAP;
                        else decide = 1;
                    end
                    else if (mgap[i] > 1) mgap[i]--;
                    else if (mgap[i] == 1) begin mgap[i] = 0; decide = 1; end
                    else begin decide = 1; may_bypass = 1; end

                    if (decide) begin
                        if (mlen[i] > 0) begin
                            mcur[i] = mq[i][0];
                            for (int k = 0; k < DEPTH - 1; k++) mq[i][k] = mq[i][k+1];
                            mlen[i]--;
                            msend[i] = HOLD;
                        end else if (may_bypass && c != 0) begin
                            mcur[i] = c; msend[i] = HOLD; taken = 1;
                        end
                    end
                    if (c != 0 && !taken) begin
                        if (mlen[i] < DEPTH) begin mq[i][mlen[i]] = c; mlen[i]++; end
                        else drop = 1;
                    end
                end
                outc        = (msend[i] > 0) ? mcur[i] : 0;
                exp_b0[i]   = outc[0];
                exp_b1[i]   = outc[1];
                exp_b2[i]   = outc[2];
                exp_busy[i] = (msend[i] > 0) || (mgap[i] > 0) || (mlen[i] > 0);
            end
            if (drop)         movf[i] = 1'b1;
            else if (CLR_OVF) movf[i] = 1'b0;
            exp_ovf[i] = movf[i];
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int code_of(input int ch);
        return int'({ENC_BIT2[ch], ENC_BIT1[ch], ENC_BIT0[ch]});
    endfunction

    task automatic step(input string tag);
        @(posedge CLK);
        model_clock();
        #1;
        chk({tag, ".b0"},   ENC_BIT0, exp_b0);
        chk({tag, ".b1"},   ENC_BIT1, exp_b1);
        chk({tag, ".b2"},   ENC_BIT2, exp_b2);
        chk({tag, ".busy"}, BUSY,     exp_busy);
        chk({tag, ".ovf"},  OVERFLOW, exp_ovf);
    endtask

    task automatic set_idle();
        PRE_LCT_OUT = '0;
        L1A_MATCH   = '0;
        L1ACFEB     = 1'b0;
        RESYNC_RST  = 1'b0;
        CLR_OVF     = 1'b0;
    endtask

    int             exp_single [4] = '{1, 1, 0, 0};
    int             exp_b2b    [9] = '{1, 1, 0, 2, 2, 0, 3, 3, 0};
    int             exp_rs     [8] = '{7, 7, 7, 7, 7, 0, 0, 0};
    logic [NCH-1:0] saved;

    initial begin
        RST_N = 1'b0; ENCODE = 1'b1; DCFEB_IN_USE = 1'b0;
        set_idle();
        model_reset();

        // reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst.b0", ENC_BIT0, '0);
        chk("rst.b1", ENC_BIT1, '0);
        chk("rst.b2", ENC_BIT2, '0);
        chk("rst.busy", BUSY, '0);
        chk("rst.ovf", OVERFLOW, '0);
        RST_N = 1'b1;
        step("idle");

        // single event on channel 2
        PRE_LCT_OUT = 5'b00100;
        for (int t = 0; t < 4; t++) begin
            step("single");
            chk_int($sformatf("single.ch2.t%0d", t), code_of(2), exp_single[t]);
            set_idle();
        end

        // back-to-back codes 1,2,3 on channel 0
        for (int t = 0; t < 9; t++) begin
            set_idle();
            if (t < 3) PRE_LCT_OUT = 5'b00001;
            if (t == 1 || t == 2) L1ACFEB = 1'b1;
            if (t == 2) L1A_MATCH = 5'b00001;
            step("b2b");
            chk_int($sformatf("b2b.ch0.t%0d", t), code_of(0), exp_b2b[t]);
            chk_int($sformatf("b2b.busy0.t%0d", t), int'(BUSY[0]), 1);
        end
        set_idle();
        repeat (20) step("drain1");

        // overflow on channel 4: 12 consecutive code-1 events
        for (int t = 0; t < 12; t++) begin
            PRE_LCT_OUT = 5'b10000;
            step("ovf");
            if (t == 6) chk_int("ovf.full_push_pop", int'(OVERFLOW[4]), 0);
            if (t == 7) chk_int("ovf.dropped", int'(OVERFLOW[4]), 1);
        end
        set_idle();
        repeat (40) step("drain2");
        chk_int("ovf.sticky", int'(OVERFLOW[4]), 1);
        CLR_OVF = 1'b1;
        step("clr_ovf");
        CLR_OVF = 1'b0;
        chk_int("ovf.cleared", int'(OVERFLOW[4]), 0);

        // resync with two codes queued on every channel
        PRE_LCT_OUT = '1;
        repeat (3) step("rs_fill");
        for (int t = 0; t < 8; t++) begin
            RESYNC_RST = (t < 3);
            PRE_LCT_OUT = (t < 3) ? '1 : '0;
            step("rs");
            for (int ch = 0; ch < NCH; ch++)
                chk_int($sformatf("rs.ch%0d.t%0d", ch, t), code_of(ch), exp_rs[t]);
        end
        chk("rs.busy_after", BUSY, '0);
        set_idle();
        repeat (6) step("rs_tail");

        // legacy modes
        DCFEB_IN_USE = 1'b1;
        L1A_MATCH = 5'b10101;
        L1ACFEB = 1'b1;
        step("dcfeb");
        chk("dcfeb.b0", ENC_BIT0, 5'b10101);
        chk("dcfeb.b1", ENC_BIT1, 5'b11111);
        chk("dcfeb.b2", ENC_BIT2, 5'b00000);
        DCFEB_IN_USE = 1'b0;
        ENCODE = 1'b0;
        saved = NCH'($urandom);
        PRE_LCT_OUT = saved;
        L1A_MATCH = ~saved;
        L1ACFEB = 1'b0;
        RESYNC_RST = 1'b1;
        step("legacy");
        chk("legacy.b0", ENC_BIT0, saved);
        chk("legacy.b2", ENC_BIT2, 5'b11111);
        chk("legacy.busy", BUSY, 5'b00000);
        set_idle();
        ENCODE = 1'b1;
        step("back_to_enc");

        // randomized traffic with resyncs, clears and mode switches
        for (int n = 0; n < 3000; n++) begin
            PRE_LCT_OUT = NCH'($urandom) & NCH'($urandom);
            L1A_MATCH   = NCH'($urandom) & NCH'($urandom) & NCH'($urandom);
            L1ACFEB     = ($urandom_range(0, 7) == 0);
            RESYNC_RST  = ($urandom_range(0, 60) == 0);
            CLR_OVF     = ($urandom_range(0, 40) == 0);
            if (ENCODE && $urandom_range(0, 150) == 0) ENCODE = 1'b0;
            else if (!ENCODE && $urandom_range(0, 15) == 0) ENCODE = 1'b1;
            if ($urandom_range(0, 300) == 0) DCFEB_IN_USE = ~DCFEB_IN_USE;
            step("rand");
        end
        set_idle();
        ENCODE = 1'b1;
        DCFEB_IN_USE = 1'b0;
        repeat (30) step("drain3");

        // asynchronous reset mid-SEND with three codes queued on channel 0
        for (int t = 0; t < 5; t++) begin
            PRE_LCT_OUT = 5'b00001;
            step("pre_rst");
        end
        set_idle();
        chk_int("pre_rst.busy0", int'(BUSY[0]), 1);
        #3;
        RST_N = 1'b0;
        #1;
        chk("arst.b0", ENC_BIT0, '0);
        chk("arst.b1", ENC_BIT1, '0);
        chk("arst.b2", ENC_BIT2, '0);
        chk("arst.busy", BUSY, '0);
        chk("arst.ovf", OVERFLOW, '0);
        @(posedge CLK);
        #1;
        model_reset();
        RST_N = 1'b1;
        repeat (6) step("post_rst");
        chk("post_rst.busy", BUSY, '0);
        chk("post_rst.ovf", OVERFLOW, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
